dw_gray_fifo_ctl: RTL and testbench

Single-clock FIFO pointer controller. It sequences push and pop requests against an external dual-port RAM of depth 2^addr_width and produces the RAM addresses, write enable, status flags and word count. It also produces registered Gray-coded read/write pointers for export to a downstream synchronizer. Binary-to-Gray conversion is done by the library DW_bin2gray component.

---
 rtl/dw_fifo_pkg.sv | 23 ++
 rtl/DW_bin2gray.sv | 11 +
 rtl/dw_gray_fifo_ctl.sv | 91 +++++++++
 tb/tb_dw_gray_fifo_ctl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/dw_fifo_pkg.sv
// Shared types, constants and Gray-code helper for the Gray-pointer FIFO controller.
package dw_fifo_pkg;

    // Default RAM address width; the controller re-sizes its pointers from its own parameter.
    localparam int ADDR_WIDTH = 3;
    localparam int DEPTH      = 1 << ADDR_WIDTH;

    // Widest pointer the controller supports (addr_width up to 16 plus the wrap bit).
    localparam int MAX_PTR_W  = 17;

    typedef logic [ADDR_WIDTH:0] ptr_t;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] g);
        logic [MAX_PTR_W-1:0] b;
        b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
        for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/DW_bin2gray.sv
// Binary to Gray code converter (combinational).
module DW_bin2gray #(
    parameter int width = 4
) (
    input  logic [width-1:0] b,
    output logic [width-1:0] g
);

    assign g = b ^ (b >> 1);

endmodule

// File: rtl/dw_gray_fifo_ctl.sv
// Single-clock FIFO pointer controller with registered status flags, word count,
// sticky overflow/underflow error and registered Gray-coded pointers for export.
module dw_gray_fifo_ctl
    import dw_fifo_pkg::*;
#(
    parameter int addr_width = 3,
    parameter int af_level   = (1 << addr_width) - 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_req,
    input  logic                  pop_req,
    output logic                  wr_en,
    output logic [addr_width-1:0] wr_addr,
    output logic [addr_width-1:0] rd_addr,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic [addr_width:0]   count,
    output logic [addr_width:0]   wr_ptr_gray,
    output logic [addr_width:0]   rd_ptr_gray,
    output logic                  error
);

    localparam int PW = addr_width + 1;
    localparam logic [addr_width:0] FULL_LVL = PW'(1 << addr_width);
    localparam logic [addr_width:0] AF_LVL   = PW'(af_level);

    logic [addr_width:0] wr_ptr;
    logic [addr_width:0] rd_ptr;
    logic [addr_width:0] wr_ptr_next;
    logic [addr_width:0] rd_ptr_next;
    logic [addr_width:0] count_next;
    logic [addr_width:0] wr_gray_next;
    logic [addr_width:0] rd_gray_next;
    logic                push_ok;
    logic                pop_ok;
    logic                error_next;

    // Requests are qualified by the registered flags; nothing is accepted during reset.
    assign push_ok = push_req & ~full  & ~rst;
    assign pop_ok  = pop_req  & ~empty & ~rst;
    assign wr_en   = push_ok;

    assign wr_addr = wr_ptr[addr_width-1:0];
    assign rd_addr = rd_ptr[addr_width-1:0];

    // The wrap bit makes pointer difference unambiguous, since occupancy never exceeds depth.
    assign wr_ptr_next = wr_ptr + {{addr_width{1'b0}}, push_ok};
    assign rd_ptr_next = rd_ptr + {{addr_width{1'b0}}, pop_ok};
    assign count_next  = wr_ptr_next - rd_ptr_next;

    assign error_next  = error | (push_req & full) | (pop_req & empty);

    // Converting the next pointers keeps each Gray register aligned with its binary pointer.
    DW_bin2gray #(.width(PW)) u_wr_b2g (
        .b (wr_ptr_next),
        .g (wr_gray_next)
    );

    DW_bin2gray #(.width(PW)) u_rd_b2g (
        .b (rd_ptr_next),
        .g (rd_gray_next)
    );

    // Pointer, count, flag, Gray and sticky-error state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_ptr_gray <= '0;
            rd_ptr_gray <= '0;
            error       <= 1'b0;
        end else begin
            wr_ptr      <= wr_ptr_next;
            rd_ptr      <= rd_ptr_next;
            count       <= count_next;
            empty       <= (count_next == '0);
            full        <= (count_next == FULL_LVL);
            almost_full <= (count_next >= AF_LVL);
            wr_ptr_gray <= wr_gray_next;
            rd_ptr_gray <= rd_gray_next;
            error       <= error_next;
        end
    end

endmodule

// File: tb/tb_dw_gray_fifo_ctl.sv
// Directed self-checking bench for dw_gray_fifo_ctl with addr_width = 2, af_level = 3.
module tb_dw_gray_fifo_ctl;
    import dw_fifo_pkg::*;

    logic       clk;
    logic       rst;
    logic       push_req;
    logic       pop_req;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [1:0] rd_addr;
    logic       empty;
    logic       full;
    logic       almost_full;
    logic [2:0] count;
    logic [2:0] wr_ptr_gray;
    logic [2:0] rd_ptr_gray;
    logic       error;

    int n_tests;
    int n_fail;

    dw_gray_fifo_ctl #(.addr_width(2), .af_level(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .push_req    (push_req),
        .pop_req     (pop_req),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .rd_addr     (rd_addr),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .count       (count),
        .wr_ptr_gray (wr_ptr_gray),
        .rd_ptr_gray (rd_ptr_gray),
        .error       (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply the current inputs across one rising edge, returning at the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".count"}, 32'(count), 32'd0);
        chk({tag, ".empty"}, 32'(empty), 32'd1);
        chk({tag, ".full"},  32'(full), 32'd0);
        chk({tag, ".af"},    32'(almost_full), 32'd0);
        chk({tag, ".error"}, 32'(error), 32'd0);
        chk({tag, ".wr_addr"}, 32'(wr_addr), 32'd0);
        chk({tag, ".rd_addr"}, 32'(rd_addr), 32'd0);
        chk({tag, ".wr_gray"}, 32'(wr_ptr_gray), 32'd0);
        chk({tag, ".rd_gray"}, 32'(rd_ptr_gray), 32'd0);
        chk({tag, ".wr_en"}, 32'(wr_en), 32'd0);
    endtask

    logic [2:0] push_gray [4]  = '{3'b001, 3'b011, 3'b010, 3'b110};
    logic [2:0] push_cnt  [4]  = '{3'd1, 3'd2, 3'd3, 3'd4};
    logic       push_af   [4]  = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic       push_full [4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [2:0] wrap_gray [9]  = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110,
                                   3'b111, 3'b101, 3'b100, 3'b000};

    initial begin
        logic [2:0] prev_wr;
        logic [2:0] prev_rd;
        int         mwr;
        int         mrd;

        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b1;
        push_req = 1'b1;
        pop_req  = 1'b0;

        // Reset held with a push request pending: everything at reset values, no write strobe.
        @(negedge clk);
        tick();
        chk_reset_state("rst");

        // Idle: empty stays high for 10 cycles.
        rst      = 1'b0;
        push_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("idle%0d.empty", i), 32'(empty), 32'd1);
        end
        chk("idle.count", 32'(count), 32'd0);

        // Four pushes fill the FIFO.
        for (int i = 0; i < 4; i++) begin
            push_req = 1'b1;
            #1;
            chk($sformatf("push%0d.wr_en", i), 32'(wr_en), 32'd1);
            chk($sformatf("push%0d.wr_addr", i), 32'(wr_addr), 32'(i));
            tick();
            chk($sformatf("push%0d.count", i), 32'(count), 32'(push_cnt[i]));
            chk($sformatf("push%0d.wr_gray", i), 32'(wr_ptr_gray), 32'(push_gray[i]));
            chk($sformatf("push%0d.af", i), 32'(almost_full), 32'(push_af[i]));
            chk($sformatf("push%0d.full", i), 32'(full), 32'(push_full[i]));
            chk($sformatf("push%0d.empty", i), 32'(empty), 32'd0);
        end

        // Fifth push while full is dropped and raises error.
        #1;
        chk("ovf.wr_en", 32'(wr_en), 32'd0);
        tick();
        chk("ovf.count", 32'(count), 32'd4);
        chk("ovf.error", 32'(error), 32'd1);
        chk("ovf.wr_gray", 32'(wr_ptr_gray), 32'b110);

        // Push + pop while full: pop accepted, push refused.
        pop_req = 1'b1;
        #1;
        chk("fullpp.wr_en", 32'(wr_en), 32'd0);
        tick();
        chk("fullpp.count", 32'(count), 32'd3);
        chk("fullpp.rd_gray", 32'(rd_ptr_gray), 32'b001);
        chk("fullpp.wr_gray", 32'(wr_ptr_gray), 32'b110);
        chk("fullpp.full", 32'(full), 32'd0);

        // Pop alone down to count 2.
        push_req = 1'b0;
        tick();
        chk("pop.count", 32'(count), 32'd2);
        chk("pop.rd_gray", 32'(rd_ptr_gray), 32'b011);
        chk("pop.rd_addr", 32'(rd_addr), 32'd2);
        chk("pop.af", 32'(almost_full), 32'd0);

        // Simultaneous push + pop at count 2: count holds, both Gray pointers step once.
        push_req = 1'b1;
        #1;
        chk("pp.wr_en", 32'(wr_en), 32'd1);
        chk("pp.wr_addr", 32'(wr_addr), 32'd0);
        tick();
        chk("pp.count", 32'(count), 32'd2);
        chk("pp.wr_gray", 32'(wr_ptr_gray), 32'b111);
        chk("pp.rd_gray", 32'(rd_ptr_gray), 32'b010);
        chk("pp.error_sticky", 32'(error), 32'd1);

        // Reset clears the sticky error.
        push_req = 1'b0;
        pop_req  = 1'b0;
        rst      = 1'b1;
        #1;
        chk("rst2.error", 32'(error), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Wrap: one push, then push/pop pairs through a full pointer cycle.
        mwr = 0;
        mrd = 0;
        for (int i = 0; i < 8; i++) begin
            prev_wr  = wr_ptr_gray;
            prev_rd  = rd_ptr_gray;
            push_req = 1'b1;
            pop_req  = (i != 0);
            tick();
            mwr = (mwr + 1) % 8;
            if (i != 0) mrd = (mrd + 1) % 8;
            chk($sformatf("wrap%0d.wr_gray", i), 32'(wr_ptr_gray), 32'(wrap_gray[i+1]));
            chk($sformatf("wrap%0d.wr_1bit", i), 32'($countones(wr_ptr_gray ^ prev_wr)), 32'd1);
            chk($sformatf("wrap%0d.wr_g2b", i), 32'(gray2bin(17'(wr_ptr_gray))), 32'(mwr));
            chk($sformatf("wrap%0d.rd_g2b", i), 32'(gray2bin(17'(rd_ptr_gray))), 32'(mrd));
            if (i != 0) begin
                chk($sformatf("wrap%0d.rd_1bit", i), 32'($countones(rd_ptr_gray ^ prev_rd)), 32'd1);
            end
            chk($sformatf("wrap%0d.count", i), 32'(count), 32'd1);
        end
        chk("wrap.error", 32'(error), 32'd0);

        // Drain to empty, then pop on empty.
        push_req = 1'b0;
        pop_req  = 1'b1;
        tick();
        chk("drain.count", 32'(count), 32'd0);
        chk("drain.empty", 32'(empty), 32'd1);
        chk("drain.error", 32'(error), 32'd0);
        prev_rd = rd_ptr_gray;
        tick();
        chk("unf.error", 32'(error), 32'd1);
        chk("unf.rd_gray", 32'(rd_ptr_gray), 32'(prev_rd));
        chk("unf.rd_addr", 32'(rd_addr), 32'd0);
        chk("unf.count", 32'(count), 32'd0);

        // Burst to count 3, then asynchronous reset between edges.
        pop_req  = 1'b0;
        push_req = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("burst.count", 32'(count), 32'd3);
        chk("burst.af", 32'(almost_full), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_state("arst");
        push_req = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("post.empty", 32'(empty), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
